// File: rtl/div_pkg.sv
// Shared constants and state encoding for the restoring divider.
package div_pkg;

    localparam int DIV_DW    = 128;
    localparam int DIV_CNT_W = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_restore_if.sv
// Request/response handshake bundle between a divider client and div_restore.
interface div_restore_if import div_pkg::*; #(
    parameter int DW = DIV_DW
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend_hi;
    logic [DW-1:0] dividend_lo;
    logic [DW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quo;
    logic [DW-1:0] rem;
    logic          div_by_zero;
    logic          overflow;

    modport master (
        output in_valid, dividend_hi, dividend_lo, divisor, out_ready,
        input  in_ready, out_valid, quo, rem, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend_hi, dividend_lo, divisor, out_ready,
        output in_ready, out_valid, quo, rem, div_by_zero, overflow
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int DW = 128
) (
    input  logic [DW:0]   r,
    input  logic          nbit,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem,
    output logic          q
);
    logic [DW:0]   r_sh;
    logic [DW+1:0] diff;

    // Single subtractor; its borrow doubles as the compare result.  A set
    // r[DW] means the shifted value is beyond any DW-bit divisor.
    always_comb begin
        r_sh = {r[DW-1:0], nbit};
        diff = {1'b0, r_sh} - {2'b00, divisor};
        q    = r[DW] | ~diff[DW+1];
        rem  = q ? diff[DW:0] : r_sh;
    end
endmodule

// File: rtl/div_restore.sv
// Restoring divider: 2*DW-bit dividend by DW-bit divisor, one quotient bit
// per clock, with zero-divisor and quotient-overflow early exits.
module div_restore import div_pkg::*; #(
    parameter int DW = DIV_DW
) (
    input  logic        clk,
    input  logic        rst,
    div_restore_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [DW:0]   r;
    logic [DW-1:0] sh;
    logic [DW-1:0] dvs;
    logic [DW-1:0] quo_q, rem_q;
    logic          dbz_q, ovf_q;

    logic [DW:0]   step_r, step_rem;
    logic          step_bit, step_q;
    logic [DW-1:0] step_dvs;
    logic          accept, is_zero, is_ovf, last;

    // In IDLE the step unit is free, so it is borrowed to evaluate
    // dividend_hi >= divisor for the overflow check: feeding hi>>1 plus
    // hi[0] as the shifted-in bit reconstructs hi exactly.
    always_comb begin
        step_r   = {2'b00, bus.dividend_hi[DW-1:1]};
        step_bit = bus.dividend_hi[0];
        step_dvs = bus.divisor;
        if (state == CALC) begin
            step_r   = r;
            step_bit = sh[DW-1];
            step_dvs = dvs;
        end
    end

    div_step #(.DW(DW)) u_step (
        .r       (step_r),
        .nbit    (step_bit),
        .divisor (step_dvs),
        .rem     (step_rem),
        .q       (step_q)
    );

    assign accept  = bus.in_valid && (state == IDLE);
    assign is_zero = (bus.divisor == '0);
    assign is_ovf  = !is_zero && step_q;
    assign last    = (state == CALC) && (cnt == CW'(DW - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (is_zero || is_ovf) ? DONE : CALC;
            CALC: if (last) state_nx = DONE;
            DONE: if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Result registers and step counter; early exits resolve at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            quo_q <= '0;
            rem_q <= '0;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            dbz_q <= is_zero;
            ovf_q <= is_ovf;
            if (is_zero) begin
                quo_q <= '1;
                rem_q <= bus.dividend_lo;
            end else if (is_ovf) begin
                quo_q <= '1;
                rem_q <= '0;
            end
        end else if (state == CALC) begin
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                quo_q <= {sh[DW-2:0], step_q};
                rem_q <= step_rem[DW-1:0];
            end
        end
    end

    // Working datapath: remainder, and a shifter that drains dividend bits
    // from the top while quotient bits fill in from the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            r   <= {1'b0, bus.dividend_hi};
            sh  <= bus.dividend_lo;
            dvs <= bus.divisor;
        end else if (state == CALC) begin
            r   <= step_rem;
            sh  <= {sh[DW-2:0], step_q};
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quo         = quo_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_div_restore.sv
// Directed-vector bench for div_restore at DW=128 with a random tail.
module tb_div_restore;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_restore_if #(.DW(DW)) bus ();

    div_restore #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string         name;
        logic [DW-1:0] hi, lo, dvs;
        logic [DW-1:0] q, r;
        logic          dbz, ovf;
        int            lat;
        int            stall;
    } vec_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one operation, keep garbage on the inputs while busy, measure
    // latency, hold the result under stall, then pop it.
    task automatic run_op(input vec_t v);
        int lat;
        bus.dividend_hi = v.hi;
        bus.dividend_lo = v.lo;
        bus.divisor     = v.dvs;
        bus.in_valid    = 1'b1;
        bus.out_ready   = 1'b0;
        tick();
        check({v.name, " in_ready busy"}, 256'(bus.in_ready), 256'(0));
        bus.dividend_hi = ~v.hi;
        bus.dividend_lo = ~v.lo;
        bus.divisor     = v.dvs + 1'b1;
        lat = 1;
        while (!bus.out_valid && lat < 400) begin
            bus.out_ready = 1'b1;
            tick();
            lat++;
        end
        bus.out_ready = 1'b0;
        check({v.name, " latency"}, 256'(lat), 256'(v.lat));
        check({v.name, " quo"}, 256'(bus.quo), 256'(v.q));
        check({v.name, " rem"}, 256'(bus.rem), 256'(v.r));
        check({v.name, " dbz"}, 256'(bus.div_by_zero), 256'(v.dbz));
        check({v.name, " ovf"}, 256'(bus.overflow), 256'(v.ovf));
        for (int s = 0; s < v.stall; s++) begin
            tick();
            check({v.name, " stall valid"}, 256'(bus.out_valid), 256'(1));
            check({v.name, " stall quo"}, 256'(bus.quo), 256'(v.q));
            check({v.name, " stall rem"}, 256'(bus.rem), 256'(v.r));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({v.name, " pop valid"}, 256'(bus.out_valid), 256'(0));
        check({v.name, " pop in_ready"}, 256'(bus.in_ready), 256'(1));
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [255:0]  full, eq, er;
        vec_t          v;
        ones = '1;

        vecs[0] = '{"100/7",      '0, 128'd100, 128'd7, 128'd14, 128'd2, 1'b0, 1'b0, 129, 2};
        vecs[1] = '{"2^128/2",    128'd1, '0, 128'd2, 128'd1 << 127, '0, 1'b0, 1'b0, 129, 0};
        vecs[2] = '{"div0",       '0, 128'h55, '0, ones, 128'h55, 1'b1, 1'b0, 1, 3};
        vecs[3] = '{"ovf eq",     128'd5, 128'd9, 128'd5, ones, '0, 1'b0, 1'b1, 1, 1};
        vecs[4] = '{"9/3",        '0, 128'd9, 128'd3, 128'd3, '0, 1'b0, 1'b0, 129, 0};
        vecs[5] = '{"lo/1",       '0, ones, 128'd1, ones, '0, 1'b0, 1'b0, 129, 1};
        vecs[6] = '{"max quo",    128'd4, ones, 128'd5, ones, 128'd4, 1'b0, 1'b0, 129, 0};
        vecs[7] = '{"999/1000",   '0, 128'd999, 128'd1000, '0, 128'd999, 1'b0, 1'b0, 129, 0};
        vecs[8] = '{"ovf ones",   ones, '0, ones, ones, '0, 1'b0, 1'b1, 1, 0};
        vecs[9] = '{"div0 hi",    128'd7, 128'habc, '0, ones, 128'habc, 1'b1, 1'b0, 1, 0};

        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b0;
        bus.dividend_hi = '0;
        bus.dividend_lo = '0;
        bus.divisor     = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst out_valid", 256'(bus.out_valid), 256'(0));
        check("rst in_ready", 256'(bus.in_ready), 256'(1));
        check("rst quo", 256'(bus.quo), 256'(0));
        check("rst rem", 256'(bus.rem), 256'(0));
        check("rst dbz", 256'(bus.div_by_zero), 256'(0));
        check("rst ovf", 256'(bus.overflow), 256'(0));

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset on the 60th CALC edge aborts the operation
        bus.dividend_hi = '0;
        bus.dividend_lo = 128'd100;
        bus.divisor     = 128'd7;
        bus.in_valid    = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (59) tick();
        check("midcalc busy", 256'(bus.in_ready), 256'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", 256'(bus.out_valid), 256'(0));
        check("midrst in_ready", 256'(bus.in_ready), 256'(1));
        check("midrst quo", 256'(bus.quo), 256'(0));
        tick();
        check("midrst idle out_valid", 256'(bus.out_valid), 256'(0));
        check("midrst idle in_ready", 256'(bus.in_ready), 256'(1));
        v = vecs[4];
        v.name = "post-rst 9/3";
        run_op(v);

        // Random operations against a 256-bit reference
        for (int k = 0; k < 60; k++) begin
            v.dvs = {$urandom(), $urandom(), $urandom(), $urandom()} >> $urandom_range(0, 127);
            if (v.dvs == '0) v.dvs = 128'd1;
            v.hi  = {$urandom(), $urandom(), $urandom(), $urandom()} % v.dvs;
            v.lo  = {$urandom(), $urandom(), $urandom(), $urandom()};
            full  = {v.hi, v.lo};
            eq    = full / {128'd0, v.dvs};
            er    = full % {128'd0, v.dvs};
            v.name  = $sformatf("rnd%0d", k);
            v.q     = eq[DW-1:0];
            v.r     = er[DW-1:0];
            v.dbz   = 1'b0;
            v.ovf   = 1'b0;
            v.lat   = 129;
            v.stall = $urandom_range(0, 3);
            run_op(v);
            check({v.name, " invariant"},
                  256'(bus.quo) * {128'd0, v.dvs} + 256'(bus.rem), full);
            check({v.name, " rem<dvs"}, 256'(bus.rem < v.dvs), 256'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
